lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage of the rv32i core; sits directly upstream of the data memory interface and converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide memory accesses.
- Byte order on the memory side is big-endian: byte offset 0 of a word is bits [31:24].
- Sub-word stores use read-modify-write, because the memory port always writes 4 bytes.
- Loads are extracted and sign- or zero-extended. Misaligned accesses and memory timeouts are flagged instead of performed.

Parameters:
- TIMEOUT_CYC, 16, max cycles waiting for mem_rdy in READ before aborting with error (>=1).

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- req  input  1  request strobe; sampled only when ready=1
- is_store  input  1  1=store, 0=load
- funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- ready  output  1  1 when in IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, illegal funct3, or timeout
- load_data  output  32  extended load result, valid with done
- mem_ren  output  1  to memory read enable
- mem_wen  output  1  to memory write enable
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wd  output  32  write word
- mem_rd  input  32  read word from memory
- mem_rdy  input  1  read data valid

Behaviour:
- Reset values:
  - state=IDLE, ready=1.
  - All other outputs 0, including mem_ren, mem_wen and load_data.
  - Timeout counter 0.
- Assertion of rst forces the reset values immediately at any point, including mid-READ or mid-WRITE. No partial write is completed.
- States and transitions:
  - IDLE: on req, latch is_store, funct3, addr and wdata, then go to CHECK.
  - CHECK:
    - Misaligned if H/HU/SH has addr[0]=1, or W/SW has addr[1:0]!=0.
    - Illegal if funct3 is not in the list above, or is_store=1 with funct3[2]=1.
    - Either fault: go to RESP with err=1; no mem_ren or mem_wen is ever issued.
    - Otherwise SW goes to WRITE; loads, SB and SH go to READ.
  - READ:
    - mem_ren=1 and mem_addr is the aligned address.
    - On mem_rdy=1, capture mem_rd into rbuf and clear the counter.
    - After capture, loads go to RESP and SB/SH go to WRITE.
    - Counter increments each cycle without mem_rdy. When it reaches TIMEOUT_CYC, go to RESP with err=1.
  - WRITE:
    - mem_wen=1 for exactly one cycle.
    - SW: mem_wd=wdata.
    - SB: rbuf with byte (3-addr[1]:addr[0]) replaced by wdata[7:0].
    - SH: rbuf with halfword addr[1] replaced by wdata[15:0]; offset 0 is bits [31:16].
    - Go to RESP.
  - RESP: done=1 for one cycle, then go to IDLE.
- Load extraction from rbuf:
  - Byte at offset k is rbuf[31-8k -: 8].
  - Halfword at offset 0 is [31:16]; offset 2 is [15:0].
  - B/H sign-extend; BU/HU zero-extend; W passes rbuf unchanged.
- load_data is 0 on store, error, and timeout. It holds its value until the next done.
- mem_* outputs are Moore functions of state and latched request only; there is no combinational path from req.
- Latency with zero-wait memory (mem_rdy in the first READ cycle), counting from the req-accept edge:
  - load: done after 4 cycles
  - SW: done after 3 cycles
  - SB/SH: done after 5 cycles
  - fault: done after 2 cycles
- req while ready=0 is ignored. The core holds the stage stalled until done.
- mem_rdy outside READ is ignored.

Test Plan:
- Memory word 0x11223344 at 0x10: SW 0x11223344 to 0x10, then LW 0x10 -> done, err=0, load_data=0x11223344; LB 0x11 -> 0x00000022.
- Word 0x80FF7F01 at 0x20: LB 0x20 -> 0xFFFFFF80; LBU 0x21 -> 0x000000FF; LH 0x22 -> 0x00007F01; LHU 0x20 -> 0x000080FF.
- Word 0x11223344 at 0x10: SB 0xAB to 0x12 -> one READ then one mem_wen with mem_wd=0x1122AB44; SH 0xBEEF to 0x10 -> mem_wd=0xBEEF3344.
- LW at 0x0E, SH at 0x13, and funct3=011 -> each gives done with err=1 two cycles after accept, and mem_ren/mem_wen never assert.
- LW 0x10 with mem_rdy held 0 -> mem_ren high for 16 cycles, then done with err=1 and load_data=0; a following request is accepted normally.
- Assert rst during READ of an SB -> outputs return to reset values immediately, no mem_wen is issued, and ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM-stage load/store unit: word-wide big-endian accesses, sub-word stores by read-modify-write
module lsu_mem_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] load_data_o,
  output logic        mem_ren_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_rdy_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t          state_q;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rbuf_q;
  logic [CW-1:0]   cnt_q;
  logic            got_q;
  logic            fault_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;
  logic [31:0]     load_data_q;
  logic            mem_ren_q;
  logic            mem_wen_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wd_q;

  logic            bad_d;
  logic            is_sw_d;
  logic [31:0]     load_d;
  logic [31:0]     merge_d;
  logic [31:0]     aligned_d;

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign load_data_o = load_data_q;
  assign mem_ren_o   = mem_ren_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wd_o    = mem_wd_q;

  // Decode of the latched request: fault detection, load extraction and store merge
  always_comb begin
    logic legal;
    logic misaligned;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    legal      = 1'b0;
    misaligned = 1'b0;
    byte_v     = 8'h00;
    half_v     = 16'h0000;
    load_d     = rbuf_q;
    merge_d    = wdata_q;
    aligned_d  = {addr_q[31:2], 2'b00};

    case (f3_q)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !store_q;
      default:                legal = 1'b0;
    endcase

    if (f3_q[1:0] == 2'b01 && addr_q[0])            misaligned = 1'b1;
    if (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) misaligned = 1'b1;

    bad_d   = !legal || misaligned;
    is_sw_d = store_q && (f3_q == 3'b010);

    // Byte offset 0 is the most significant byte of the word
    case (addr_q[1:0])
      2'd0:    byte_v = rbuf_q[31:24];
      2'd1:    byte_v = rbuf_q[23:16];
      2'd2:    byte_v = rbuf_q[15:8];
      default: byte_v = rbuf_q[7:0];
    endcase
    half_v = addr_q[1] ? rbuf_q[15:0] : rbuf_q[31:16];

    case (f3_q[1:0])
      2'b00:   load_d = {{24{byte_v[7] & !f3_q[2]}}, byte_v};
      2'b01:   load_d = {{16{half_v[15] & !f3_q[2]}}, half_v};
      default: load_d = rbuf_q;
    endcase

    case (f3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merge_d = {wdata_q[7:0], rbuf_q[23:0]};
          2'd1:    merge_d = {rbuf_q[31:24], wdata_q[7:0], rbuf_q[15:0]};
          2'd2:    merge_d = {rbuf_q[31:16], wdata_q[7:0], rbuf_q[7:0]};
          default: merge_d = {rbuf_q[31:8], wdata_q[7:0]};
        endcase
      end
      2'b01:   merge_d = addr_q[1] ? {rbuf_q[31:16], wdata_q[15:0]}
                                   : {wdata_q[15:0], rbuf_q[15:0]};
      default: merge_d = wdata_q;
    endcase
  end

  // Request sequencer; every output is a register so nothing passes combinationally from req
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rbuf_q      <= 32'h0;
      cnt_q       <= '0;
      got_q       <= 1'b0;
      fault_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wd_q    <= 32'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            store_q <= is_store_i;
            f3_q    <= funct3_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            ready_q <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad_d) begin
            fault_q <= 1'b1;
            state_q <= S_RESP;
          end else if (is_sw_d) begin
            mem_wen_q  <= 1'b1;
            mem_addr_q <= aligned_d;
            mem_wd_q   <= wdata_q;
            state_q    <= S_WRITE;
          end else begin
            mem_ren_q  <= 1'b1;
            mem_addr_q <= aligned_d;
            cnt_q      <= '0;
            got_q      <= 1'b0;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (got_q) begin
            // Word captured on the previous edge; rbuf is now stable for extraction/merge
            got_q <= 1'b0;
            if (store_q) begin
              mem_wen_q <= 1'b1;
              mem_wd_q  <= merge_d;
              state_q   <= S_WRITE;
            end else begin
              mem_addr_q <= 32'h0;
              state_q    <= S_RESP;
            end
          end else if (mem_rdy_i) begin
            rbuf_q    <= mem_rd_i;
            cnt_q     <= '0;
            got_q     <= 1'b1;
            mem_ren_q <= 1'b0;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            cnt_q      <= '0;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            fault_q    <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          mem_wen_q  <= 1'b0;
          mem_wd_q   <= 32'h0;
          mem_addr_q <= 32'h0;
          state_q    <= S_RESP;
        end
        S_RESP: begin
          done_q      <= 1'b1;
          err_q       <= fault_q;
          load_data_q <= (fault_q || store_q) ? 32'h0 : load_d;
          fault_q     <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed and random checks of lsu_mem_stage against a word-memory model
module tb_lsu_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        ready_o, done_o, err_o, mem_ren_o, mem_wen_o, mem_rdy_i;
  logic [31:0] load_data_o, mem_addr_o, mem_wd_o, mem_rd_i;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  int          rdy_wait = 0;
  int          ren_age = 0;
  bit          noise = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ld_obs;

  lsu_mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .load_data_o(load_data_o),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .mem_rdy_i(mem_rdy_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_ren_o) ren_age <= 0;
    else            ren_age <= ren_age + 1;
  end

  assign mem_rd_i  = mem[mem_addr_o[7:2]];
  assign mem_rdy_i = (mem_ren_o && ren_age >= rdy_wait) || (!mem_ren_o && noise);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one request computed from the architectural rules
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int w,
                                output bit e, output logic [31:0] ld, output int lat,
                                output int rens, output int wens, output logic [31:0] nw);
    logic [31:0] word, mask, v;
    int size, k, sh;
    bit legal;
    word  = ref_mem[a[7:2]];
    k     = int'(a[1:0]);
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) && !(st && f3[2]);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mask  = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh    = 8 * (4 - size - k);
    e = 1'b0; ld = 32'h0; lat = 0; rens = 0; wens = 0; nw = word;
    if (!legal || (k % size) != 0) begin
      e = 1'b1; lat = 2;
    end else if (st && size == 4) begin
      wens = 1; nw = wd; lat = 3;
    end else if (w >= TO) begin
      e = 1'b1; lat = TO + 2; rens = TO;
    end else if (st) begin
      rens = w + 1; wens = 1; lat = 5 + w;
      nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      rens = w + 1; lat = 4 + w;
      v = (word >> sh) & mask;
      if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 32'h1) == 32'h1) v = v | ~mask;
      ld = v;
    end
  endfunction

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int w, output logic [31:0] ld_o);
    bit e_err; logic [31:0] e_ld, e_nw; int e_lat, e_rens, e_wens;
    int rens, wens, lat; logic [31:0] radr, wadr, wdo; logic err_s, rdy_s;
    model(st, f3, a, wd, w, e_err, e_ld, e_lat, e_rens, e_wens, e_nw);
    rens = 0; wens = 0; lat = 0; radr = 0; wadr = 0; wdo = 0; err_s = 0; rdy_s = 0; ld_o = 0;
    rdy_wait = w;
    noise = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("ready_idle", {31'h0, ready_o}, 32'h1);
    req_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk);
    #1;
    req_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
    chk("ready_busy", {31'h0, ready_o}, 32'h0);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ren_o) begin rens++; radr = mem_addr_o; end
      if (mem_wen_o) begin
        wens++; wdo = mem_wd_o; wadr = mem_addr_o;
        mem[mem_addr_o[7:2]] = mem_wd_o;
      end
      if (done_o) begin
        lat = c; err_s = err_o; ld_o = load_data_o; rdy_s = ready_o;
        break;
      end
    end
    chk("done_latency", lat, e_lat);
    chk("err", {31'h0, err_s}, {31'h0, e_err});
    chk("load_data", ld_o, e_ld);
    chk("ready_at_done", {31'h0, rdy_s}, 32'h1);
    chk("ren_cycles", rens, e_rens);
    chk("wen_cycles", wens, e_wens);
    if (e_rens > 0) chk("ren_addr", radr, {a[31:2], 2'b00});
    if (e_wens > 0) begin
      chk("wen_addr", wadr, {a[31:2], 2'b00});
      chk("mem_wd", wdo, e_nw);
      ref_mem[a[7:2]] = e_nw;
    end
    @(negedge clk);
    chk("done_pulse", {31'h0, done_o}, 32'h0);
    chk("ld_hold", load_data_o, e_ld);
    noise = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, ready_o}, 32'h1);
    chk({tag, "_done"}, {31'h0, done_o}, 32'h0);
    chk({tag, "_err"}, {31'h0, err_o}, 32'h0);
    chk({tag, "_ld"}, load_data_o, 32'h0);
    chk({tag, "_ren"}, {31'h0, mem_ren_o}, 32'h0);
    chk({tag, "_wen"}, {31'h0, mem_wen_o}, 32'h0);
    chk({tag, "_maddr"}, mem_addr_o, 32'h0);
    chk({tag, "_mwd"}, mem_wd_o, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_i = 1'b0;

    // Word 0x11223344 at 0x10
    do_op(1, 3'b010, 32'h10, 32'h11223344, 0, ld_obs);
    do_op(0, 3'b010, 32'h10, 32'h0, 0, ld_obs);
    chk("plan_lw", ld_obs, 32'h11223344);
    do_op(0, 3'b000, 32'h11, 32'h0, 0, ld_obs);
    chk("plan_lb", ld_obs, 32'h00000022);

    // Word 0x80FF7F01 at 0x20
    do_op(1, 3'b010, 32'h20, 32'h80FF7F01, 0, ld_obs);
    do_op(0, 3'b000, 32'h20, 32'h0, 0, ld_obs);
    chk("plan_lb_neg", ld_obs, 32'hFFFFFF80);
    do_op(0, 3'b100, 32'h21, 32'h0, 0, ld_obs);
    chk("plan_lbu", ld_obs, 32'h000000FF);
    do_op(0, 3'b001, 32'h22, 32'h0, 0, ld_obs);
    chk("plan_lh", ld_obs, 32'h00007F01);
    do_op(0, 3'b101, 32'h20, 32'h0, 0, ld_obs);
    chk("plan_lhu", ld_obs, 32'h000080FF);

    // Sub-word stores by read-modify-write
    do_op(1, 3'b000, 32'h12, 32'hFFFFFFAB, 0, ld_obs);
    chk("plan_sb_word", mem[4], 32'h1122AB44);
    do_op(1, 3'b010, 32'h10, 32'h11223344, 0, ld_obs);
    do_op(1, 3'b001, 32'h10, 32'h1234BEEF, 2, ld_obs);
    chk("plan_sh_word", mem[4], 32'hBEEF3344);

    // Faults: misaligned and illegal width
    do_op(0, 3'b010, 32'h0E, 32'h0, 0, ld_obs);
    do_op(1, 3'b001, 32'h13, 32'h5555, 0, ld_obs);
    do_op(0, 3'b011, 32'h10, 32'h0, 0, ld_obs);
    do_op(1, 3'b100, 32'h10, 32'h0, 0, ld_obs);

    // Timeout, then a normal request, then a slow memory
    do_op(0, 3'b010, 32'h10, 32'h0, 1000, ld_obs);
    do_op(0, 3'b010, 32'h10, 32'h0, 0, ld_obs);
    do_op(0, 3'b001, 32'h16, 32'h0, TO - 1, ld_obs);

    // Reset asserted while an SB sits in READ
    rdy_wait = 1000;
    @(negedge clk);
    req_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h12; wdata_i = 32'h5A;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_ren_o) break;
    end
    chk("rst_in_read", {31'h0, mem_ren_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_wen", {31'h0, mem_wen_o}, 32'h0);
    end
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_mem_untouched", mem[4], ref_mem[4]);
    do_op(0, 3'b010, 32'h10, 32'h0, 1, ld_obs);

    // Random requests
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
            $urandom, $urandom_range(0, 4), ld_obs);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
